// File: rtl/mac_tx_arbiter.sv
// Round-robin arbiter sharing one MAC transmitter among NREQ frame sources,
// with grant hold/timeout, a minimum inter-frame gap and link-down gating.
module mac_tx_arbiter #(
  parameter int unsigned NREQ       = 4,
  parameter int unsigned IFG_CYCLES = 12,
  parameter int unsigned TIMEOUT    = 4096
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     link_up,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ-1:0]          done,
  output logic [NREQ-1:0]          grant,
  output logic [$clog2(NREQ)-1:0]  grant_idx,
  output logic                     tx_busy,
  output logic                     timeout
);

  localparam int unsigned IDX_W  = $clog2(NREQ);
  localparam int unsigned HOLD_W = $clog2(TIMEOUT);
  localparam int unsigned GAP_W  = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_GAP   = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [NREQ-1:0]     grant_q, grant_d;
  logic [IDX_W-1:0]    grant_idx_q, grant_idx_d;
  logic [IDX_W-1:0]    ptr_q, ptr_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [GAP_W-1:0]    gap_q, gap_d;
  logic                tx_busy_q, tx_busy_d;
  logic                timeout_q, timeout_d;

  logic                win_found_c;
  logic [IDX_W-1:0]    win_idx_c;
  logic [IDX_W-1:0]    scan_idx;

  // Round-robin search starting just after the last winner.
  always_comb begin
    win_found_c = 1'b0;
    win_idx_c   = '0;
    scan_idx    = '0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      scan_idx = IDX_W'((32'(ptr_q) + i) % NREQ);
      if (!win_found_c && req[scan_idx]) begin
        win_found_c = 1'b1;
        win_idx_c   = scan_idx;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    grant_idx_d = grant_idx_q;
    ptr_d       = ptr_q;
    hold_d      = hold_q;
    gap_d       = gap_q;
    timeout_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (link_up && win_found_c) begin
          grant_d            = '0;
          grant_d[win_idx_c] = 1'b1;
          grant_idx_d        = win_idx_c;
          ptr_d              = win_idx_c;
          hold_d             = '0;
          state_d            = S_GRANT;
        end
      end
      S_GRANT: begin
        // A done on the expiry cycle wins over the timeout.
        if (done[grant_idx_q]) begin
          grant_d = '0;
          gap_d   = GAP_W'(IFG_CYCLES - 1);
          state_d = S_GAP;
        end else if (hold_q == HOLD_W'(TIMEOUT - 1)) begin
          grant_d   = '0;
          timeout_d = 1'b1;
          gap_d     = GAP_W'(IFG_CYCLES - 1);
          state_d   = S_GAP;
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      S_GAP: begin
        if (gap_q == '0) begin
          state_d = S_IDLE;
        end else begin
          gap_d = gap_q - GAP_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        grant_d = '0;
      end
    endcase

    tx_busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      grant_q     <= '0;
      grant_idx_q <= '0;
      ptr_q       <= IDX_W'(NREQ - 1);
      hold_q      <= '0;
      gap_q       <= '0;
      tx_busy_q   <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      grant_idx_q <= grant_idx_d;
      ptr_q       <= ptr_d;
      hold_q      <= hold_d;
      gap_q       <= gap_d;
      tx_busy_q   <= tx_busy_d;
      timeout_q   <= timeout_d;
    end
  end

  assign grant     = grant_q;
  assign grant_idx = grant_idx_q;
  assign tx_busy   = tx_busy_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_mac_tx_arbiter.sv
// Bench for mac_tx_arbiter: frame-level reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_mac_tx_arbiter;

  localparam int NREQ = 4;
  localparam int IFG  = 12;
  localparam int TMO  = 16;

  logic       clock     = 1'b0;
  logic       reset_n   = 1'b0;
  logic       link_up   = 1'b0;
  logic [3:0] req       = 4'b0;
  logic [3:0] done_man  = 4'b0;
  logic [3:0] done_auto = 4'b0;
  logic [3:0] done;
  logic [3:0] grant;
  logic [1:0] grant_idx;
  logic       tx_busy;
  logic       timeout;

  assign done = done_man | done_auto;

  always #5 clock = ~clock;

  mac_tx_arbiter #(.NREQ(NREQ), .IFG_CYCLES(IFG), .TIMEOUT(TMO)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .link_up   (link_up),
    .req       (req),
    .done      (done),
    .grant     (grant),
    .grant_idx (grant_idx),
    .tx_busy   (tx_busy),
    .timeout   (timeout)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, got, exp);
    end
  endtask

  // Reference model: current owner, cycles held, quiet cycles since last frame.
  int   m_owner = -1;
  int   m_held  = 0;
  int   m_quiet = IFG;
  int   m_ptr   = NREQ - 1;
  int   m_idx   = 0;
  logic m_tout  = 1'b0;
  int   m_c;
  logic m_hit;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_owner = -1; m_held = 0; m_quiet = IFG;
      m_ptr = NREQ - 1; m_idx = 0; m_tout = 1'b0;
    end else begin
      m_tout = 1'b0;
      if (m_owner >= 0) begin
        if (done[m_owner[1:0]]) begin
          m_owner = -1; m_quiet = 0;
        end else if (m_held + 1 == TMO) begin
          m_owner = -1; m_quiet = 0; m_tout = 1'b1;
        end else begin
          m_held++;
        end
      end else if (m_quiet < IFG) begin
        m_quiet++;
      end else if (link_up && req != 4'b0) begin
        m_hit = 1'b0;
        for (int s = 1; s <= NREQ; s++) begin
          m_c = (m_ptr + s) % NREQ;
          if (!m_hit && req[m_c[1:0]]) begin
            m_hit = 1'b1;
            m_owner = m_c;
          end
        end
        m_ptr = m_owner; m_idx = m_owner; m_held = 0;
      end
    end
  end

  logic [3:0] e_grant;
  logic       e_busy;

  always @(negedge clock) begin
    e_grant = 4'b0;
    if (m_owner >= 0) e_grant[m_owner[1:0]] = 1'b1;
    e_busy = (m_owner >= 0) || (m_quiet < IFG);
    n_checks++;
    if (grant !== e_grant || grant_idx !== 2'(m_idx) || tx_busy !== e_busy || timeout !== m_tout) begin
      n_fail++;
      $display("FAIL model t=%0t: got grant=%b idx=%0d busy=%b tout=%b, required grant=%b idx=%0d busy=%b tout=%b",
               $time, grant, grant_idx, tx_busy, timeout, e_grant, m_idx, e_busy, m_tout);
    end
  end

  // Source responder (done after a delay) and grant-sequence recorder.
  int         auto_mode = 0;
  int         auto_dly  = 5;
  int         age       = 0;
  int         cur_dly   = 0;
  int         low_run   = 0;
  logic [3:0] last_g    = 4'b0;
  int         rise_q[$];
  int         low_q[$];

  always @(posedge clock) begin
    #2;
    if (grant != 4'b0) begin
      if (grant != last_g) begin
        age = 1;
        cur_dly = (auto_mode == 2) ? int'($urandom_range(1, 20)) : auto_dly;
        for (int b = 0; b < NREQ; b++) if (grant[b]) rise_q.push_back(b);
        low_q.push_back(low_run);
      end else begin
        age++;
      end
      low_run = 0;
    end else begin
      age = 0;
      low_run++;
    end
    last_g = grant;
    done_auto = (auto_mode != 0 && grant != 4'b0 && age == cur_dly) ? grant : 4'b0;
  end

  task automatic wait_idle();
    int n = 0;
    while (tx_busy !== 1'b0 && n < 400) begin
      @(negedge clock);
      n++;
    end
    chk("wait_idle", int'(tx_busy), 0);
  endtask

  int exp_order[5] = '{0, 1, 2, 3, 0};
  int hi, tc, n;
  logic seen;

  initial begin
    @(negedge clock);
    chk("rst_grant", grant, 0);
    chk("rst_idx", grant_idx, 0);
    chk("rst_busy", tx_busy, 0);
    chk("rst_tout", timeout, 0);
    @(negedge clock);
    reset_n = 1'b1;

    // All sources requesting, done 5 cycles into each grant.
    rise_q.delete(); low_q.delete();
    link_up = 1'b1; req = 4'b1111; auto_mode = 1; auto_dly = 5;
    repeat (110) @(negedge clock);
    req = 4'b0;
    wait_idle();
    chk("t1_frames", (rise_q.size() >= 5) ? 1 : 0, 1);
    if (rise_q.size() >= 5)
      for (int i = 0; i < 5; i++) chk($sformatf("t1_order%0d", i), rise_q[i], exp_order[i]);
    if (low_q.size() >= 5)
      for (int i = 1; i < 5; i++) chk($sformatf("t1_gap%0d", i), low_q[i], IFG + 1);

    // Single requester, manual done.
    auto_mode = 0;
    repeat (2) @(negedge clock);
    req = 4'b0100;
    @(negedge clock);
    chk("t2_grant", grant, 4);
    chk("t2_idx", grant_idx, 2);
    chk("t2_busy", tx_busy, 1);
    done_man = 4'b0100;
    @(negedge clock);
    done_man = 4'b0; req = 4'b0;
    chk("t2_release", grant, 0);
    n = 0;
    while (tx_busy === 1'b1 && n < 100) begin
      n++;
      @(negedge clock);
    end
    chk("t2_busy_tail", n, IFG);

    // Source 1 never finishes: timeout, then the next requester.
    wait_idle();
    rise_q.delete(); low_q.delete();
    req = 4'b0010;
    @(negedge clock);
    chk("t3_grant", grant, 2);
    req = 4'b1010;
    hi = 1; tc = 0;
    while (grant != 4'b0 && hi < 100) begin
      @(negedge clock);
      if (timeout) tc++;
      if (grant != 4'b0) hi++;
    end
    auto_mode = 1; auto_dly = 3;
    repeat (20) begin
      @(negedge clock);
      if (timeout) tc++;
    end
    req = 4'b0;
    chk("t3_hold_len", hi, TMO);
    chk("t3_tout_pulses", tc, 1);
    wait_idle();
    chk("t3_next", (rise_q.size() >= 2) ? rise_q[1] : -1, 3);
    chk("t3_gap", (low_q.size() >= 2) ? low_q[1] : -1, IFG + 1);

    // Link down blocks new grants but not an ongoing frame.
    auto_mode = 0;
    link_up = 1'b0; req = 4'b0011; seen = 1'b0;
    repeat (20) begin
      @(negedge clock);
      if (grant != 4'b0) seen = 1'b1;
    end
    chk("t4_no_grant", seen, 0);
    link_up = 1'b1;
    @(negedge clock);
    chk("t4_grant", grant, 1);
    link_up = 1'b0; seen = 1'b0;
    repeat (8) begin
      @(negedge clock);
      if (grant != 4'b0001) seen = 1'b1;
    end
    chk("t4_hold_linkdown", seen, 0);
    done_man = 4'b0001;
    @(negedge clock);
    done_man = 4'b0;
    chk("t4_release", grant, 0);
    req = 4'b0; link_up = 1'b1;
    wait_idle();

    // Foreign done and dropped req ignored; done on expiry cycle beats timeout.
    req = 4'b0001;
    @(negedge clock);
    chk("t5_grant", grant, 1);
    for (int k = 1; k <= TMO; k++) begin
      if (k == 1) req = 4'b0;
      done_man = (k == 2) ? 4'b1000 : (k == TMO) ? 4'b0001 : 4'b0000;
      if (k == TMO - 1) chk("t5_hold", grant, 1);
      @(negedge clock);
    end
    done_man = 4'b0;
    chk("t5_release", grant, 0);
    chk("t5_no_tout", timeout, 0);
    @(negedge clock);
    chk("t5_no_tout_late", timeout, 0);
    wait_idle();

    // Asynchronous reset mid-grant.
    req = 4'b0100;
    @(negedge clock);
    chk("t6_grant", grant, 4);
    @(negedge clock);
    #3;
    reset_n = 1'b0;
    #1;
    chk("t6_async_grant", grant, 0);
    chk("t6_async_busy", tx_busy, 0);
    req = 4'b1000;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    chk("t6_regrant", grant, 8);
    chk("t6_regrant_idx", grant_idx, 3);
    auto_mode = 1; auto_dly = 4; req = 4'b0;
    wait_idle();

    // Randomized traffic, spurious done pulses, link flaps, timeouts.
    auto_mode = 2;
    for (int c = 0; c < 1500; c++) begin
      @(negedge clock);
      link_up = ($urandom_range(0, 9) != 0);
      for (int b = 0; b < NREQ; b++)
        if ($urandom_range(0, 5) == 0) req[b] = ~req[b];
      done_man = ($urandom_range(0, 15) == 0) ? 4'($urandom_range(0, 15)) : 4'b0;
    end
    req = 4'b0; done_man = 4'b0; link_up = 1'b1;
    wait_idle();
    repeat (2) @(negedge clock);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
